// File: rtl/frac_clken_pkg.sv
// Shared types and parameter defaults/bounds for the fractional clock-enable generator.
package frac_clken_pkg;

  localparam int NUM_CH_DEF      = 3;
  localparam int NUM_CH_MIN      = 1;
  localparam int NUM_CH_MAX      = 8;
  localparam int ACC_W_DEF       = 32;
  localparam int ACC_W_MIN       = 8;
  localparam int ACC_W_MAX       = 32;
  localparam int LOCK_PULSES_DEF = 4;
  localparam int LOCK_PULSES_MIN = 1;
  localparam int LOCK_PULSES_MAX = 255;
  localparam int LOCK_CNT_W      = 8;
  localparam int CH_W_MAX        = 3;

  typedef enum logic [0:0] {
    SLOT_EMPTY   = 1'b0,
    SLOT_PENDING = 1'b1
  } slot_state_e;

  // Shadow slot sized for the largest build; narrower builds zero-extend into it
  typedef struct packed {
    logic [CH_W_MAX-1:0]  ch;
    logic [ACC_W_MAX-1:0] inc;
    logic                 en;
  } cfg_slot_t;

  function automatic int ch_width(input int n);
    if (n > 1) begin
      ch_width = $clog2(n);
    end else begin
      ch_width = 1;
    end
  endfunction

endpackage

// File: rtl/frac_clken_gen_if.sv
// Configuration request channel: one shadow-slot write per valid/ready transfer.
interface frac_clken_gen_if
  import frac_clken_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ACC_W  = ACC_W_DEF
) ();

  localparam int CH_W = ch_width(NUM_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic             cfg_en;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_inc, cfg_en,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_inc, cfg_en,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/frac_clken_ch.sv
// One phase-accumulator channel: emits a carry pulse per overflow and reports lock
// once enough pulses have followed the last configuration change.
module frac_clken_ch
  import frac_clken_pkg::*;
#(
  parameter int ACC_W       = ACC_W_DEF,
  parameter int LOCK_PULSES = LOCK_PULSES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             apply_i,
  input  logic [ACC_W-1:0] inc_i,
  input  logic             en_i,
  output logic             can_apply_o,
  output logic             clken_o,
  output logic             locked_o
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_CNT = LOCK_CNT_W'(LOCK_PULSES);

  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [ACC_W-1:0]      inc_q, inc_d;
  logic                  en_q, en_d;
  logic                  clken_q, clken_d;
  logic                  locked_q, locked_d;
  logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W:0]        sum_s;
  logic                  carry_s;

  assign sum_s   = {1'b0, acc_q} + {1'b0, inc_q};
  assign carry_s = en_q & sum_s[ACC_W];

  // A running channel only takes new config on a pulse boundary so the rate never glitches
  assign can_apply_o = ~en_q | (inc_q == '0) | carry_s;
  assign clken_o     = clken_q;
  assign locked_o    = locked_q;

  // Accumulate, take shadow config on apply, and count pulses toward lock
  always_comb begin
    acc_d   = acc_q;
    inc_d   = inc_q;
    en_d    = en_q;
    clken_d = 1'b0;
    cnt_d   = cnt_q;
    if (apply_i) begin
      inc_d = inc_i;
      en_d  = en_i;
      cnt_d = '0;
      if (en_i && carry_s) begin
        acc_d   = sum_s[ACC_W-1:0];
        clken_d = 1'b1;
      end else begin
        acc_d   = '0;
        clken_d = 1'b0;
      end
    end else if (en_q) begin
      acc_d   = sum_s[ACC_W-1:0];
      clken_d = carry_s;
      if (carry_s && (cnt_q != LOCK_CNT)) begin
        cnt_d = cnt_q + LOCK_CNT_W'(1'b1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      acc_d   = '0;
      clken_d = 1'b0;
      cnt_d   = '0;
    end
    locked_d = (cnt_d == LOCK_CNT);
  end

  // Channel state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      inc_q    <= '0;
      en_q     <= 1'b0;
      clken_q  <= 1'b0;
      locked_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      inc_q    <= inc_d;
      en_q     <= en_d;
      clken_q  <= clken_d;
      locked_q <= locked_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/frac_clken_gen.sv
// Multi-channel fractional clock-enable generator: config handshake and single
// shadow slot here, per-channel accumulators in frac_clken_ch.
module frac_clken_gen
  import frac_clken_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int LOCK_PULSES = LOCK_PULSES_DEF
) (
  input  logic              refclk,
  input  logic              rst_n,
  frac_clken_gen_if.slave   cfg,
  output logic [NUM_CH-1:0] clken,
  output logic [NUM_CH-1:0] locked
);

  localparam int            CH_W     = ch_width(NUM_CH);
  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  slot_state_e       state_q, state_d;
  cfg_slot_t         slot_q, slot_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              xfer_s;
  logic              bad_ch_s;
  logic              apply_any_s;
  logic              slot_unused_s;
  logic [CH_W-1:0]   slot_ch_s;
  logic [NUM_CH-1:0] can_apply_s;
  logic [NUM_CH-1:0] apply_s;

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;
  assign xfer_s        = cfg.cfg_valid & ready_q;
  assign bad_ch_s      = ({1'b0, cfg.cfg_ch} >= NUM_CH_L);
  assign slot_ch_s     = slot_q.ch[CH_W-1:0];
  assign apply_any_s   = |apply_s;
  // Upper slot bits are only live in the widest builds
  assign slot_unused_s = ^slot_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign apply_s[i] = (state_q == SLOT_PENDING) && (slot_ch_s == CH_W'(i)) && can_apply_s[i];

    frac_clken_ch #(
      .ACC_W       (ACC_W),
      .LOCK_PULSES (LOCK_PULSES)
    ) u_ch (
      .clk_i       (refclk),
      .rst_ni      (rst_n),
      .apply_i     (apply_s[i]),
      .inc_i       (slot_q.inc[ACC_W-1:0]),
      .en_i        (slot_q.en),
      .can_apply_o (can_apply_s[i]),
      .clken_o     (clken[i]),
      .locked_o    (locked[i])
    );
  end

  // Shadow-slot next state: accept when empty, drop bad targets, free on apply
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    err_d   = 1'b0;
    case (state_q)
      SLOT_EMPTY: begin
        if (xfer_s && bad_ch_s) begin
          err_d   = 1'b1;
          state_d = SLOT_EMPTY;
        end else if (xfer_s) begin
          state_d                 = SLOT_PENDING;
          slot_d                  = '0;
          slot_d.ch[CH_W-1:0]     = cfg.cfg_ch;
          slot_d.inc[ACC_W-1:0]   = cfg.cfg_inc;
          slot_d.en               = cfg.cfg_en;
        end else begin
          state_d = SLOT_EMPTY;
        end
      end
      SLOT_PENDING: begin
        if (apply_any_s) begin
          state_d = SLOT_EMPTY;
        end else begin
          state_d = SLOT_PENDING;
        end
      end
      default: begin
        state_d = SLOT_EMPTY;
      end
    endcase
    ready_d = (state_d == SLOT_EMPTY);
  end

  // Handshake and slot registers; ready stays low until the first edge out of reset
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      slot_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_frac_clken_gen.sv
// Directed scoreboard bench: expected pulse/lock/error events are queued ahead of
// each config write and a negedge monitor matches every observed event.
module tb_frac_clken_gen;

  localparam int NUM_CH      = 3;
  localparam int ACC_W       = 8;
  localparam int LOCK_PULSES = 4;
  localparam int K_CLK  = 0;
  localparam int K_RISE = 1;
  localparam int K_FALL = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int kind;
    int ch;
    int cyc;
  } ev_t;

  logic              refclk = 1'b0;
  logic              rst_n  = 1'b0;
  logic [NUM_CH-1:0] clken;
  logic [NUM_CH-1:0] locked;
  logic [NUM_CH-1:0] locked_prev = '0;
  int                cyc = 0;
  int                n_cmp = 0;
  int                n_fail = 0;
  int                xe;
  ev_t               exp_q[$];

  frac_clken_gen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) cfg_if ();

  frac_clken_gen #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_PULSES (LOCK_PULSES)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .cfg    (cfg_if),
    .clken  (clken),
    .locked (locked)
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic string kname(input int k);
    case (k)
      K_CLK:   kname = "clken";
      K_RISE:  kname = "locked_rise";
      K_FALL:  kname = "locked_fall";
      default: kname = "cfg_err";
    endcase
  endfunction

  task automatic push(input int k, input int ch, input int c);
    exp_q.push_back('{k, ch, c});
  endtask

  task automatic push_series(input int ch, input int first, input int step, input int last);
    for (int c = first; c <= last; c += step) push(K_CLK, ch, c);
  endtask

  task automatic match(input int k, input int ch);
    int idx = -1;
    for (int j = 0; j < exp_q.size(); j++) begin
      if (exp_q[j].kind == k && exp_q[j].ch == ch && exp_q[j].cyc == cyc) begin
        idx = j;
        break;
      end
    end
    n_cmp++;
    if (idx < 0) begin
      n_fail++;
      $display("FAIL %s ch%0d: got event at edge %0d, expected none", kname(k), ch, cyc);
    end else begin
      exp_q.delete(idx);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge refclk);
  endtask

  // Called at a negedge; returns the edge number on which the transfer happened
  task automatic cfg_write(input int ch, input int inc, input int en, output int x);
    int n = 0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_inc   = 8'(inc);
    cfg_if.cfg_en    = 1'(en);
    while (!cfg_if.cfg_ready && n < 300) begin
      @(negedge refclk);
      n++;
    end
    if (!cfg_if.cfg_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL xfer_timeout ch%0d: cfg_ready got 0, expected 1 within 300 cycles", ch);
      x = -1;
    end else begin
      x = cyc + 1;
    end
    @(negedge refclk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  // Event monitor
  always @(negedge refclk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clken[i])                   match(K_CLK, i);
        if (locked[i] && !locked_prev[i]) match(K_RISE, i);
        if (!locked[i] && locked_prev[i]) match(K_FALL, i);
      end
      if (cfg_if.cfg_err) match(K_ERR, 0);
    end
    locked_prev = locked;
  end

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_inc   = '0;
    cfg_if.cfg_en    = 1'b0;
    repeat (3) @(negedge refclk);
    chk("reset_ready", int'(cfg_if.cfg_ready), 0);
    chk("reset_err", int'(cfg_if.cfg_err), 0);
    chk("reset_clken", int'(clken), 0);
    chk("reset_locked", int'(locked), 0);
    rst_n = 1'b1;
    @(negedge refclk);
    chk("ready_after_reset", int'(cfg_if.cfg_ready), 1);

    // ch0 inc=64 from disabled: apply at 3, pulses every 4th edge, lock on the 4th
    push_series(0, 7, 4, 23);
    push(K_RISE, 0, 19);
    cfg_write(0, 64, 1, xe);
    chk("xfer_ch0_inc64", xe, 2);
    chk("ready_while_pending", int'(cfg_if.cfg_ready), 0);
    @(negedge refclk);
    chk("ready_after_apply", int'(cfg_if.cfg_ready), 1);
    wait_until(23);
    chk("locked0_inc64", int'(locked[0]), 1);

    // ch0 -> inc=128: applies on the pulse at 27, then spacing 2, relock at 35
    push(K_CLK, 0, 27);
    push(K_FALL, 0, 27);
    push_series(0, 29, 2, 457);
    push(K_RISE, 0, 35);
    cfg_write(0, 128, 1, xe);
    chk("xfer_ch0_inc128", xe, 24);
    chk("ready_until_ch0_pulse", int'(cfg_if.cfg_ready), 0);

    // Held request must wait for the slot to free at 27
    push(K_CLK, 1, 115);
    push(K_CLK, 1, 200);
    push(K_CLK, 1, 285);
    push(K_CLK, 1, 371);
    push(K_RISE, 1, 371);
    cfg_write(1, 3, 1, xe);
    chk("xfer_ch1_held", xe, 28);

    // ch1 -> inc=0: applies on its next carry at 456, silent afterwards
    wait_until(380);
    push(K_CLK, 1, 456);
    push(K_FALL, 1, 456);
    cfg_write(1, 0, 1, xe);
    chk("xfer_ch1_inc0", xe, 381);

    // Out-of-range channel: one err pulse, slot stays free
    push(K_ERR, 0, 457);
    cfg_write(3, 77, 1, xe);
    chk("xfer_bad_ch", xe, 457);
    chk("ready_after_err", int'(cfg_if.cfg_ready), 1);

    // Disable ch0: applies at carry edge 459 with no pulse
    push(K_FALL, 0, 459);
    cfg_write(0, 0, 0, xe);
    chk("xfer_ch0_off", xe, 458);

    push_series(2, 469, 8, 501);
    push(K_RISE, 2, 493);
    cfg_write(2, 32, 1, xe);
    chk("xfer_ch2_inc32", xe, 460);

    // Pending write to ch2, then reset before it can apply
    wait_until(501);
    cfg_write(2, 16, 1, xe);
    chk("xfer_ch2_inc16", xe, 502);
    chk("locked_before_reset", int'(locked), 4);
    @(negedge refclk);
    @(negedge refclk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_clken", int'(clken), 0);
    chk("midreset_locked", int'(locked), 0);
    chk("midreset_ready", int'(cfg_if.cfg_ready), 0);
    chk("midreset_err", int'(cfg_if.cfg_err), 0);
    @(negedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
    @(negedge refclk);
    chk("ready_after_rerelease", int'(cfg_if.cfg_ready), 1);
    repeat (40) @(negedge refclk);
    chk("no_stale_clken", int'(clken), 0);
    chk("no_stale_locked", int'(locked), 0);
    chk("no_stale_ready", int'(cfg_if.cfg_ready), 1);

    while (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL missing_%s ch%0d: got no event, expected one at edge %0d",
               kname(exp_q[0].kind), exp_q[0].ch, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frac_clken_gen.md
FRAC_CLKEN_GEN -- requirements
Module: frac_clken_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of independent clock-enable channels (1..8).
REQ-002 SHALL have parameter ACC_W, default 32: phase-accumulator width in bits (8..32).
REQ-003 SHALL have parameter LOCK_PULSES, default 4: enable pulses needed after a config apply before locked asserts (1..255).
REQ-004 SHALL have port refclk  in  1  sole clock; all logic rises on it.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port cfg_valid  in  1  config request.
REQ-007 SHALL have port cfg_ready  out  1  config slot free.
REQ-008 SHALL have port cfg_ch  in  clog2(NUM_CH) (min 1)  target channel.
REQ-009 SHALL have port cfg_inc  in  ACC_W  phase increment; output rate = f_refclk * inc / 2^ACC_W.
REQ-010 SHALL have port cfg_en  in  1  channel enable to apply.
REQ-011 SHALL have port cfg_err  out  1  one-cycle pulse: accepted request had cfg_ch >= NUM_CH.
REQ-012 SHALL have port clken  out  NUM_CH  per-channel one-refclk-wide enable pulse.
REQ-013 SHALL have port locked  out  NUM_CH  per-channel rate-settled status.

Function
REQ-014 Per enabled channel, each cycle SHALL compute {carry, sum} = acc + inc (ACC_W+1 bits), store acc <= sum (modulo 2^ACC_W), clken[i] <= carry (registered; one-cycle latency from overflow).
REQ-015 Over any 2^ACC_W consecutive cycles at fixed inc, a channel SHALL emit exactly inc pulses; inc=0 SHALL give no pulses.
REQ-016 Disabled channel SHALL hold acc=0, clken[i]=0, locked[i]=0.
REQ-017 Handshake: transfer on rising edge with cfg_valid & cfg_ready; cfg_ready = !pending (single shadow slot {ch, inc, en}); cfg_ready SHALL NOT depend combinationally on cfg_valid.
REQ-018 Transfer SHALL set pending=1; cfg_err pulses the next cycle if cfg_ch >= NUM_CH, and that request is dropped (pending stays 0).
REQ-019 Apply, target enabled: at the first edge where the target's carry=1, clken pulse produced from old inc, acc <= sum, then inc/en take shadow values; pending <= 0. Guarantees glitch-free rate change on a pulse boundary.
REQ-020 Apply, target disabled or current inc=0: SHALL apply at the first edge after transfer; acc <= 0; pending <= 0.
REQ-021 Applying en=0 SHALL clear acc, clken[i], locked[i] at the apply edge.
REQ-022 locked[i] SHALL deassert at every apply edge for channel i, and assert on the edge on which the LOCK_PULSES-th clken[i] pulse after that apply is registered; counter saturates.
REQ-023 Rewriting a channel with identical inc/en SHALL still be treated as an apply (locked drops).
REQ-024 Channels not targeted SHALL be unaffected by any config activity.

Reset
REQ-025 While rst_n=0: all acc=0, inc=0, en=0, pending=0, cfg_ready=0, cfg_err=0, clken=0, locked=0.
REQ-026 cfg_ready SHALL go to 1 on the first refclk edge after rst_n deasserts; reset mid-pending SHALL discard the shadow slot.

Structure
REQ-027 Package frac_clken_pkg SHALL hold parameter defaults/bounds and the config-slot struct type {ch, inc, en}.
REQ-028 One sub-module frac_clken_ch (accumulator, inc/en regs, lock counter) SHALL be instantiated NUM_CH times; top holds handshake and shadow slot.

Verification
REQ-029 ACC_W=8, ch0 cfg inc=64 en=1 from reset -> applied next edge; clken[0] every 4th cycle; locked[0] with 4th pulse.
REQ-030 ACC_W=8, ch1 inc=3 -> exactly 3 pulses in any 256-cycle window; inc=0 -> zero pulses, locked stays 0.
REQ-031 ch0 running inc=64, write inc=128 -> cfg_ready low until next ch0 pulse; spacing 4 then 2; locked[0] drops at apply and returns after 4 pulses.
REQ-032 cfg_valid held during pending -> no second transfer; then write cfg_ch=3 with NUM_CH=3 -> cfg_err one pulse, no channel changes.
REQ-033 Assert rst_n=0 mid-pending while ch2 running -> all outputs 0 immediately; after release cfg_ready=1 and no stale apply occurs.
